// File: rtl/difftest_step_batcher.sv
// Batches per-core commit step counts to the host bridge and latches the deferred simulation result.
// Optional statistics counters are compiled in with DIFFTEST_STEP_BATCH_STATS_EN.
module difftest_step_batcher #(
  parameter int NUM_CORES       = 2,
  parameter int STEP_WIDTH      = 8,
  parameter int ACC_WIDTH       = 16,
  parameter int BATCH_THRESHOLD = 64,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_CORES*STEP_WIDTH-1:0] step_in,
  output logic                            stall,
  output logic                            batch_valid,
  input  logic                            batch_ready,
  output logic [ACC_WIDTH-1:0]            batch_steps,
  output logic [NUM_CORES-1:0]            batch_core_mask,
  output logic                            batch_final,
  input  logic                            result_valid,
  input  logic [7:0]                      result_in,
  output logic [7:0]                      simv_result
`ifdef DIFFTEST_STEP_BATCH_STATS_EN
  ,
  output logic [31:0]                     stat_batches,
  output logic [63:0]                     stat_steps,
  output logic [31:0]                     stat_stall_cycles
`endif
);

  localparam longint MAX_SUM = longint'(NUM_CORES) * ((64'd1 << STEP_WIDTH) - 1);
  localparam longint ACC_MAX = (64'd1 << ACC_WIDTH) - 1;
  localparam logic [ACC_WIDTH-1:0] STALL_LIMIT = ACC_WIDTH'(ACC_MAX - 2 * MAX_SUM);
  localparam logic [ACC_WIDTH-1:0] THRESH = ACC_WIDTH'(BATCH_THRESHOLD);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, HALT} state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [NUM_CORES-1:0]   mask_q, mask_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   stall_q, stall_d;
  logic                   bv_q, bv_d;
  logic [ACC_WIDTH-1:0]   bsteps_q, bsteps_d;
  logic [NUM_CORES-1:0]   bmask_q, bmask_d;
  logic                   bfinal_q, bfinal_d;
  logic [7:0]             simv_q, simv_d;

  logic [ACC_WIDTH-1:0]   sum, acc_next;
  logic [NUM_CORES-1:0]   nz, mask_next;
  logic [STEP_WIDTH-1:0]  lane;
  logic                   xfer, slot_free, expired, launch;

  always_comb begin
    sum  = '0;
    nz   = '0;
    lane = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      lane = step_in[i*STEP_WIDTH +: STEP_WIDTH];
      if (state_q != HALT) begin
        sum   = sum + ACC_WIDTH'(lane);
        nz[i] = |lane;
      end
    end
    acc_next  = acc_q + sum;
    mask_next = mask_q | nz;
    xfer      = bv_q & batch_ready;
    slot_free = ~bv_q | batch_ready;
    expired   = (TIMEOUT_CYCLES != 0) && (timer_q >= TMAX);
    launch    = (state_q != HALT) && slot_free && (acc_next != '0) &&
                ((acc_next >= THRESH) || expired || (state_q == FLUSH));

    acc_d    = acc_next;
    mask_d   = mask_next;
    bv_d     = bv_q;
    bsteps_d = bsteps_q;
    bmask_d  = bmask_q;
    bfinal_d = bfinal_q;
    timer_d  = timer_q;
    state_d  = state_q;
    simv_d   = simv_q;

    if (launch) begin
      bsteps_d = acc_next;
      bmask_d  = mask_next;
      bfinal_d = (state_q == FLUSH);
      bv_d     = 1'b1;
      acc_d    = '0;
      mask_d   = '0;
    end else if (xfer) begin
      bv_d = 1'b0;
    end

    // Saturate once expired so a long-held slot cannot wrap the timer.
    if (launch || acc_q == '0) timer_d = '0;
    else if (!expired)         timer_d = timer_q + 1'b1;

    unique case (state_q)
      IDLE, ACCUM: state_d = (acc_d != '0) ? ACCUM : IDLE;
      FLUSH:       if (acc_next == '0 && slot_free) state_d = HALT;
      HALT:        state_d = HALT;
      default:     state_d = IDLE;
    endcase

    if (result_valid && result_in != 8'd0 && simv_q == 8'd0) begin
      simv_d  = result_in;
      state_d = FLUSH;
    end

    stall_d = (acc_next > STALL_LIMIT) || (state_d == HALT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mask_q   <= '0;
      timer_q  <= '0;
      stall_q  <= 1'b0;
      bv_q     <= 1'b0;
      bsteps_q <= '0;
      bmask_q  <= '0;
      bfinal_q <= 1'b0;
      simv_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mask_q   <= mask_d;
      timer_q  <= timer_d;
      stall_q  <= stall_d;
      bv_q     <= bv_d;
      bsteps_q <= bsteps_d;
      bmask_q  <= bmask_d;
      bfinal_q <= bfinal_d;
      simv_q   <= simv_d;
    end
  end

  assign stall           = stall_q;
  assign batch_valid     = bv_q;
  assign batch_steps     = bsteps_q;
  assign batch_core_mask = bmask_q;
  assign batch_final     = bfinal_q;
  assign simv_result     = simv_q;

`ifdef DIFFTEST_STEP_BATCH_STATS_EN
  logic [31:0] sbat_q, sbat_d;
  logic [63:0] sstep_q, sstep_d;
  logic [31:0] sstall_q, sstall_d;

  always_comb begin
    sbat_d   = sbat_q + 32'(xfer);
    sstep_d  = sstep_q + (xfer ? 64'(bsteps_q) : 64'd0);
    sstall_d = sstall_q + 32'(stall_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sbat_q   <= '0;
      sstep_q  <= '0;
      sstall_q <= '0;
    end else begin
      sbat_q   <= sbat_d;
      sstep_q  <= sstep_d;
      sstall_q <= sstall_d;
    end
  end

  assign stat_batches      = sbat_q;
  assign stat_steps        = sstep_q;
  assign stat_stall_cycles = sstall_q;
`endif

endmodule

// File: tb/tb_difftest_step_batcher.sv
// Directed bench for difftest_step_batcher: threshold, timeout, stall headroom,
// result flush/halt and reset discard.
module tb_difftest_step_batcher;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] step_in;
  logic        stall;
  logic        batch_valid;
  logic        batch_ready;
  logic [15:0] batch_steps;
  logic [1:0]  batch_core_mask;
  logic        batch_final;
  logic        result_valid;
  logic [7:0]  result_in;
  logic [7:0]  simv_result;
`ifdef DIFFTEST_STEP_BATCH_STATS_EN
  logic [31:0] stat_batches;
  logic [63:0] stat_steps;
  logic [31:0] stat_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int stall_at;

  difftest_step_batcher dut (
    .clock           (clock),
    .reset           (reset),
    .step_in         (step_in),
    .stall           (stall),
    .batch_valid     (batch_valid),
    .batch_ready     (batch_ready),
    .batch_steps     (batch_steps),
    .batch_core_mask (batch_core_mask),
    .batch_final     (batch_final),
    .result_valid    (result_valid),
    .result_in       (result_in),
    .simv_result     (simv_result)
`ifdef DIFFTEST_STEP_BATCH_STATS_EN
    ,
    .stat_batches      (stat_batches),
    .stat_steps        (stat_steps),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_valid"}, batch_valid, 0);
    chk({tag, "_steps"}, batch_steps, 0);
    chk({tag, "_mask"}, batch_core_mask, 0);
    chk({tag, "_final"}, batch_final, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_simv"}, simv_result, 0);
  endtask

  initial begin
    reset        = 1'b1;
    step_in      = '0;
    batch_ready  = 1'b0;
    result_valid = 1'b0;
    result_in    = '0;
    tick();
    tick();
    chk_zero_outs("reset");
    reset = 1'b0;

    // Threshold: 10 per cycle on core0 gives a 70-step batch every 7 cycles
    batch_ready = 1'b1;
    step_in     = 16'h000A;
    for (int k = 1; k <= 21; k++) begin
      tick();
      chk("thr_valid", batch_valid, (k % 7 == 0) ? 1 : 0);
      if (k % 7 == 0) begin
        chk("thr_steps", batch_steps, 70);
        chk("thr_mask", batch_core_mask, 2'b01);
        chk("thr_final", batch_final, 0);
      end
    end
    step_in = '0;
    tick();
    chk("thr_drain", batch_valid, 0);
`ifdef DIFFTEST_STEP_BATCH_STATS_EN
    chk("stat_batches", stat_batches, 3);
    chk("stat_steps", stat_steps, 210);
    chk("stat_stall", stat_stall_cycles, 0);
`endif

    // Timeout: single 5 on core1, batch exactly 256 cycles later
    step_in = 16'h0500;
    tick();
    step_in = '0;
    repeat (255) tick();
    chk("to_early", batch_valid, 0);
    tick();
    chk("to_valid", batch_valid, 1);
    chk("to_steps", batch_steps, 5);
    chk("to_mask", batch_core_mask, 2'b10);
    tick();
    chk("to_drain", batch_valid, 0);

    // Stall headroom: host blocked, 510 per cycle
    batch_ready = 1'b0;
    step_in     = 16'hFFFF;
    tick();
    chk("st_valid", batch_valid, 1);
    chk("st_first", batch_steps, 510);
    stall_at = 0;
    for (int t = 2; t <= 1000; t++) begin
      tick();
      if (stall && stall_at == 0) stall_at = t;
      step_in = stall ? 16'h0000 : 16'hFFFF;
      chk("st_held", batch_steps, 510);
    end
    chk("st_rise", stall_at, 128);
    chk("st_stall", stall, 1);
    batch_ready = 1'b1;
    step_in     = '0;
    tick();
    chk("st_b2b_valid", batch_valid, 1);
    chk("st_b2b_steps", batch_steps, 64770);
    chk("st_b2b_mask", batch_core_mask, 2'b11);
    tick();
    chk("st_done_valid", batch_valid, 0);
    chk("st_release", stall, 0);

    // Result while acc=20: final flush then halt
    step_in = 16'h0014;
    tick();
    step_in      = '0;
    result_valid = 1'b1;
    result_in    = 8'h03;
    tick();
    result_valid = 1'b0;
    chk("res_simv", simv_result, 3);
    chk("res_nolaunch", batch_valid, 0);
    tick();
    chk("fl_valid", batch_valid, 1);
    chk("fl_steps", batch_steps, 20);
    chk("fl_final", batch_final, 1);
    chk("fl_mask", batch_core_mask, 2'b01);
    tick();
    chk("halt_valid", batch_valid, 0);
    chk("halt_stall", stall, 1);
    result_valid = 1'b1;
    result_in    = 8'h07;
    step_in      = 16'h000A;
    repeat (3) tick();
    result_valid = 1'b0;
    chk("halt_sticky", simv_result, 3);
    chk("halt_nolaunch", batch_valid, 0);
    chk("halt_stall2", stall, 1);

    // Reset discards a held batch
    step_in = '0;
    reset   = 1'b1;
    tick();
    reset       = 1'b0;
    batch_ready = 1'b0;
    step_in     = 16'h0064;
    tick();
    step_in = '0;
    chk("rs_valid", batch_valid, 1);
    chk("rs_steps", batch_steps, 100);
    tick();
    chk("rs_held", batch_valid, 1);
    reset = 1'b1;
    tick();
    chk_zero_outs("rs_clr");
    reset = 1'b0;
    tick();
    chk("rs_noreoffer", batch_valid, 0);
    result_valid = 1'b1;
    result_in    = 8'h00;
    tick();
    result_valid = 1'b0;
    chk("res_zero", simv_result, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
